// File: rtl/fpu.sv
// Single-precision add/sub/mul/div with one registered result per clock.
// Denormals are treated as zero, and round-to-nearest-even is applied to every operation.
module fpu #(
   parameter int WIDTH = 32
) (
   input  logic [0:WIDTH-1] in_data_a,
   input  logic [0:WIDTH-1] in_data_b,
   output logic [0:WIDTH-1] out_data,
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       opcode,
   output logic             done
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // Mantissa layout: [26:3] significand, [2] guard, [1:0] folded into sticky.
   function automatic logic [31:0] round_pack(input logic s, input logic signed [11:0] e,
                                              input logic [26:0] m);
      logic [24:0]        r;
      logic signed [11:0] e2;
      logic [22:0]        frac;
      logic               inc;
      inc = m[2] & ((|m[1:0]) | m[3]);
      r   = {1'b0, m[26:3]} + {24'd0, inc};
      if (r[24]) begin
         frac = r[23:1];
         e2   = e + 12'sd1;
      end else begin
         frac = r[22:0];
         e2   = e;
      end
      if (e2 >= 12'sd255)
         round_pack = {s, 8'hFF, 23'd0};
      else if (e2 <= 12'sd0)
         round_pack = {s, 31'd0};
      else
         round_pack = {s, e2[7:0], frac};
   endfunction

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      lzc27 = 5'd27;
      for (int i = 0; i < 27; i++)
         if (v[i]) lzc27 = 5'(26 - i);
   endfunction

   // Restoring division; returns {27-bit quotient, final partial remainder}.
   function automatic logic [52:0] divide(input logic [23:0] n, input logic [23:0] d);
      logic [26:0] q;
      logic [25:0] rem;
      rem = {2'b00, n};
      for (int i = 26; i >= 0; i--) begin
         if (rem >= {2'b00, d}) begin
            q[i] = 1'b1;
            rem  = rem - {2'b00, d};
         end else begin
            q[i] = 1'b0;
         end
         rem = rem << 1;
      end
      divide = {q, rem};
   endfunction

   logic [31:0] a, b, result_d, result_q;
   logic        done_q;
   logic        sa, sb, sbe, sm;
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [23:0] ma, mb;

   assign a      = in_data_a;
   assign b      = in_data_b;
   assign sa     = a[31];
   assign sb     = b[31];
   assign ea     = a[30:23];
   assign eb     = b[30:23];
   assign fa     = a[22:0];
   assign fb     = b[22:0];
   assign sbe    = sb ^ opcode[0];
   assign sm     = sa ^ sb;
   assign a_zero = (ea == 8'd0);
   assign b_zero = (eb == 8'd0);
   assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
   assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
   assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
   assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
   assign ma     = a_zero ? 24'd0 : {1'b1, fa};
   assign mb     = b_zero ? 24'd0 : {1'b1, fb};

   // Add/subtract path
   logic               swap, sl, ss;
   logic [7:0]         el, es, ediff;
   logic [23:0]        ml, ms;
   logic [4:0]         shamt, lz;
   logic [49:0]        ext;
   logic [26:0]        aligned, add_mant;
   logic [27:0]        sum;
   logic signed [11:0] add_exp;
   logic [31:0]        add_res;

   assign swap    = (a_zero ? 31'd0 : {ea, fa}) < (b_zero ? 31'd0 : {eb, fb});
   assign sl      = swap ? sbe : sa;
   assign ss      = swap ? sa  : sbe;
   assign el      = swap ? eb  : ea;
   assign es      = swap ? ea  : eb;
   assign ml      = swap ? mb  : ma;
   assign ms      = swap ? ma  : mb;
   assign ediff   = el - es;
   assign shamt   = (ediff > 8'd31) ? 5'd31 : ediff[4:0];
   assign ext     = {ms, 26'd0} >> shamt;
   assign aligned = {ext[49:24], |ext[23:0]};
   assign sum     = (sl == ss) ? {1'b0, ml, 3'd0} + {1'b0, aligned}
                               : {1'b0, ml, 3'd0} - {1'b0, aligned};

   always_comb begin
      lz = 5'd0;
      if (sum[27]) begin
         add_mant = {sum[27:2], sum[1] | sum[0]};
         add_exp  = $signed({4'd0, el}) + 12'sd1;
      end else begin
         lz       = lzc27(sum[26:0]);
         add_mant = sum[26:0] << lz;
         add_exp  = $signed({4'd0, el}) - $signed({7'd0, lz});
      end
      add_res = (sum == 28'd0) ? 32'd0 : round_pack(sl, add_exp, add_mant);
   end

   // Multiply path
   logic [47:0]        prod;
   logic [26:0]        mul_mant;
   logic signed [11:0] mul_exp;

   assign prod = ma * mb;

   always_comb begin
      if (prod[47]) begin
         mul_mant = {prod[47:24], prod[23], |prod[22:0], 1'b0};
         mul_exp  = $signed({4'd0, ea}) + $signed({4'd0, eb}) - 12'sd126;
      end else begin
         mul_mant = {prod[46:23], prod[22], |prod[21:0], 1'b0};
         mul_exp  = $signed({4'd0, ea}) + $signed({4'd0, eb}) - 12'sd127;
      end
   end

   // Divide path
   logic [52:0]        div_raw;
   logic [26:0]        quot;
   logic [25:0]        rem;
   logic [26:0]        div_mant;
   logic signed [11:0] div_exp;

   assign div_raw = divide(ma, mb);
   assign quot    = div_raw[52:26];
   assign rem     = div_raw[25:0];

   always_comb begin
      if (quot[26]) begin
         div_mant = {quot[26:3], quot[2], quot[1] | quot[0] | (rem != 26'd0), 1'b0};
         div_exp  = $signed({4'd0, ea}) - $signed({4'd0, eb}) + 12'sd127;
      end else begin
         div_mant = {quot[25:2], quot[1], quot[0] | (rem != 26'd0), 1'b0};
         div_exp  = $signed({4'd0, ea}) - $signed({4'd0, eb}) + 12'sd126;
      end
   end

   always_comb begin
      result_d = 32'd0;
      if (a_nan || b_nan) begin
         result_d = QNAN;
      end else begin
         case (opcode)
            2'b00, 2'b01: begin
               if (a_inf && b_inf)
                  result_d = (sa != sbe) ? QNAN : {sa, 8'hFF, 23'd0};
               else if (a_inf)
                  result_d = {sa, 8'hFF, 23'd0};
               else if (b_inf)
                  result_d = {sbe, 8'hFF, 23'd0};
               else
                  result_d = add_res;
            end
            2'b10: begin
               if ((a_inf && b_zero) || (b_inf && a_zero))
                  result_d = QNAN;
               else if (a_inf || b_inf)
                  result_d = {sm, 8'hFF, 23'd0};
               else if (a_zero || b_zero)
                  result_d = {sm, 31'd0};
               else
                  result_d = round_pack(sm, mul_exp, mul_mant);
            end
            default: begin
               if ((a_zero && b_zero) || (a_inf && b_inf))
                  result_d = QNAN;
               else if (a_inf || b_zero)
                  result_d = {sm, 8'hFF, 23'd0};
               else if (b_inf || a_zero)
                  result_d = {sm, 31'd0};
               else
                  result_d = round_pack(sm, div_exp, div_mant);
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result_q <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         done_q   <= 1'b1;
      end
   end

   assign out_data = result_q;
   assign done     = done_q;

endmodule

// File: tb/tb_fpu.sv
// Directed-vector bench for fpu: reset behaviour, the four operations, rounding,
// special values and asynchronous reset in mid-stream.
module tb_fpu;

   logic        clk = 1'b0;
   logic        reset;
   logic [0:31] a, b, out;
   logic [1:0]  op;
   logic        done;
   int          errors = 0;
   int          checks = 0;

   fpu #(.WIDTH(32)) dut (
      .in_data_a(a),
      .in_data_b(b),
      .out_data (out),
      .clk      (clk),
      .reset    (reset),
      .opcode   (op),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Apply operands, take one edge, then compare the registered result.
   task automatic vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                      input logic [1:0] vop, input logic [31:0] exp);
      a  = va;
      b  = vb;
      op = vop;
      @(posedge clk);
      #1;
      check(tag, out, exp);
      $display("%s: A=%08h B=%08h op=%0d -> %08h", tag, va, vb, vop, out);
   endtask

   initial begin
      reset = 1'b0;
      a     = '0;
      b     = '0;
      op    = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out", out, 32'h0);
      check("rst_done", {31'd0, done}, 32'd0);

      reset = 1'b1;
      a     = 32'h41C8_0000;
      b     = 32'h40A0_0000;
      op    = 2'b00;
      #1;
      check("pre_edge_out", out, 32'h0);
      check("pre_edge_done", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
      check("add_25_5", out, 32'h41F0_0000);
      check("done_after_edge", {31'd0, done}, 32'd1);

      op = 2'b01;
      #2;
      check("latency_hold", out, 32'h41F0_0000);
      @(posedge clk);
      #1;
      check("sub_25_5", out, 32'h41A0_0000);

      vec("mul_25_5", 32'h41C8_0000, 32'h40A0_0000, 2'b10, 32'h42FA_0000);
      vec("div_25_5", 32'h41C8_0000, 32'h40A0_0000, 2'b11, 32'h40A0_0000);
      vec("sub_5_25", 32'h40A0_0000, 32'h41C8_0000, 2'b01, 32'hC1A0_0000);
      vec("sub_1_1", 32'h3F80_0000, 32'h3F80_0000, 2'b01, 32'h0000_0000);
      vec("add_1_m1", 32'h3F80_0000, 32'hBF80_0000, 2'b00, 32'h0000_0000);
      vec("div_1_0", 32'h3F80_0000, 32'h0000_0000, 2'b11, 32'h7F80_0000);
      vec("div_0_0", 32'h0000_0000, 32'h0000_0000, 2'b11, 32'h7FC0_0000);
      vec("mul_ovf", 32'h7F7F_FFFF, 32'h4000_0000, 2'b10, 32'h7F80_0000);
      vec("div_1_3", 32'h3F80_0000, 32'h4040_0000, 2'b11, 32'h3EAA_AAAB);
      vec("add_tie_even", 32'h3F80_0000, 32'h3380_0000, 2'b00, 32'h3F80_0000);
      vec("add_round_up", 32'h3F80_0000, 32'h33C0_0000, 2'b00, 32'h3F80_0001);
      vec("mul_underflow", 32'h0080_0000, 32'h0080_0000, 2'b10, 32'h0000_0000);
      vec("div_x_minf", 32'h40A0_0000, 32'hFF80_0000, 2'b11, 32'h8000_0000);
      vec("inf_sub_inf", 32'h7F80_0000, 32'h7F80_0000, 2'b01, 32'h7FC0_0000);
      vec("nan_add", 32'h7FC0_0001, 32'h3F80_0000, 2'b00, 32'h7FC0_0000);
      vec("mul_0_inf", 32'h0000_0000, 32'h7F80_0000, 2'b10, 32'h7FC0_0000);
      vec("minf_add_1", 32'hFF80_0000, 32'h3F80_0000, 2'b00, 32'hFF80_0000);

      vec("mul_before_rst", 32'h41C8_0000, 32'h40A0_0000, 2'b10, 32'h42FA_0000);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_out", out, 32'h0);
      check("async_rst_done", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
      check("rst_held_out", out, 32'h0);
      check("rst_held_done", {31'd0, done}, 32'd0);
      reset = 1'b1;
      vec("add_after_rst", 32'h41C8_0000, 32'h40A0_0000, 2'b00, 32'h41F0_0000);
      check("done_after_rst", {31'd0, done}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
